// File: rtl/io_out_mmio_if.sv
// io_out_mmio_if: store and readback bus between the core and the output peripheral
interface io_out_mmio_if;
  logic        st_en;
  logic [7:0]  st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  modport master (output st_en, st_addr, st_data, st_strb, rd_addr, input rd_data);
  modport slave (input st_en, st_addr, st_data, st_strb, rd_addr, output rd_data);
endinterface

// File: rtl/io_out_mmio.sv
// io_out_mmio: memory-mapped LED/HEX/LCD output registers with a timed LCD write sequencer
module io_out_mmio #(
  parameter int LEDR_W    = 18,
  parameter int LEDG_W    = 9,
  parameter int NUM_HEX   = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 12,
  parameter int HOLD_CYC  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  io_out_mmio_if.slave         bus,
  output logic [LEDR_W-1:0]    o_ledr,
  output logic [LEDG_W-1:0]    o_ledg,
  output logic [7*NUM_HEX-1:0] o_hex,
  output logic [31:0]          o_lcd,
  output logic                 o_lcd_busy
);
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
  state_t state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [LEDR_W-1:0] ledr;
  logic [LEDG_W-1:0] ledg;
  logic [6:0] hex [NUM_HEX];
  logic [7:0] lcd_d;
  logic lcd_rs, lcd_on, ovr;
  logic [5:0] sw, rw;
  logic [2:0] ri;
  logic [31:0] lcd_word, lcd_new;
  logic lcd_st, accept, ovr_set, ovr_clr, busy, unused_ok;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) o[8*i+:8] = s[i] ? d[8*i+:8] : o[8*i+:8];
    return o;
  endfunction

  assign sw        = bus.st_addr[7:2];
  assign rw        = bus.rd_addr[7:2];
  assign ri        = 3'(rw - 6'd4);
  assign busy      = state != IDLE;
  assign lcd_word  = {lcd_on, 22'b0, lcd_rs, lcd_d};
  assign lcd_new   = merge(lcd_word, bus.st_data, bus.st_strb);
  assign lcd_st    = bus.st_en && sw == 6'd16;
  assign accept    = lcd_st && !busy;
  assign ovr_set   = lcd_st && busy;
  assign ovr_clr   = bus.st_en && sw == 6'd17 && bus.st_strb[0] && bus.st_data[1];
  assign unused_ok = ^{bus.st_addr[1:0], bus.rd_addr[1:0], lcd_new[30:9]};

  // One shared down-counter, reloaded with the new phase length on every state entry
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt - 16'd1;
    if (state == IDLE) begin
      cnt_nx = cnt;
      if (accept) begin
        state_nx = SETUP;
        cnt_nx   = 16'(SETUP_CYC - 1);
      end
    end else if (cnt == 16'd0) begin
      state_nx = state == SETUP ? PULSE : state == PULSE ? HOLD : IDLE;
      cnt_nx   = state == SETUP ? 16'(PULSE_CYC - 1) : state == PULSE ? 16'(HOLD_CYC - 1) : 16'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 16'd0;
      ledr   <= '0;
      ledg   <= '0;
      lcd_d  <= '0;
      lcd_rs <= 1'b0;
      lcd_on <= 1'b0;
      ovr    <= 1'b0;
      for (int k = 0; k < NUM_HEX; k++) hex[k] <= 7'h7F;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ovr   <= ovr_set | (ovr & ~ovr_clr);
      if (bus.st_en && sw == 6'd0) ledr <= LEDR_W'(merge(32'(ledr), bus.st_data, bus.st_strb));
      if (bus.st_en && sw == 6'd1) ledg <= LEDG_W'(merge(32'(ledg), bus.st_data, bus.st_strb));
      for (int k = 0; k < NUM_HEX; k++)
        if (bus.st_en && sw == 6'(4 + k) && bus.st_strb[0]) hex[k] <= bus.st_data[6:0];
      if (accept) begin
        lcd_d  <= lcd_new[7:0];
        lcd_rs <= lcd_new[8];
        lcd_on <= lcd_new[31];
      end
    end
  end

  always_comb begin
    bus.rd_data = rw == 6'd0 ? 32'(ledr) :
                  rw == 6'd1 ? 32'(ledg) :
                  (rw >= 6'd4 && rw < 6'(4 + NUM_HEX)) ? 32'(hex[ri]) :
                  rw == 6'd16 ? lcd_word :
                  rw == 6'd17 ? {30'b0, ovr, busy} : 32'd0;
  end

  for (genvar g = 0; g < NUM_HEX; g++) assign o_hex[7*g+:7] = hex[g];
  assign o_ledr     = ledr;
  assign o_ledg     = ledg;
  assign o_lcd      = {lcd_on, 20'b0, state == PULSE, 1'b0, lcd_rs, lcd_d};
  assign o_lcd_busy = busy;
endmodule

// File: tb/tb_io_out_mmio.sv
// tb_io_out_mmio: directed plus randomized checks of io_out_mmio against a register/timeline model
module tb_io_out_mmio;
  localparam int S = 2, P = 12, H = 2, TOT = S + P + H, NH = 8;
  logic clk = 0, rst = 0;
  logic [17:0] o_ledr;
  logic [8:0]  o_ledg;
  logic [55:0] o_hex;
  logic [31:0] o_lcd;
  logic        o_lcd_busy;
  int total = 0, passed = 0;
  logic [31:0] m_ledr, m_ledg, m_lcd;
  logic [6:0]  m_hex [NH];
  logic        m_ovr;
  int          t;
  logic [7:0]  addrs [14] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C,
                              8'h20, 8'h2C, 8'h30, 8'h3C, 8'h40, 8'h44, 8'hFC};

  io_out_mmio_if bus();
  io_out_mmio dut (.clk(clk), .rst(rst), .bus(bus), .o_ledr(o_ledr), .o_ledg(o_ledg),
                   .o_hex(o_hex), .o_lcd(o_lcd), .o_lcd_busy(o_lcd_busy));

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i+:8] = d[8*i+:8];
    return o;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    int w = int'(a[7:2]);
    if (w == 0) return m_ledr;
    if (w == 1) return m_ledg;
    if (w >= 4 && w < 4 + NH) return {25'b0, m_hex[w-4]};
    if (w == 16) return m_lcd;
    if (w == 17) return {30'b0, m_ovr, t != 0};
    return 32'd0;
  endfunction

  function automatic logic [55:0] exp_hex();
    logic [55:0] v;
    for (int k = 0; k < NH; k++) v[7*k+:7] = m_hex[k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_ledr = 0; m_ledg = 0; m_lcd = 0; m_ovr = 0; t = 0;
    for (int k = 0; k < NH; k++) m_hex[k] = 7'h7F;
  endtask

  // t counts cycles since the accepting edge; 0 means idle
  task automatic model_step(input logic en, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int w = int'(a[7:2]);
    bit busy_pre = t != 0;
    bit set = 0, clr = 0;
    if (t != 0) t = (t == TOT) ? 0 : t + 1;
    if (en) begin
      if (w == 0) m_ledr = merge(m_ledr, d, s) & 32'h3FFFF;
      else if (w == 1) m_ledg = merge(m_ledg, d, s) & 32'h1FF;
      else if (w >= 4 && w < 4 + NH) begin
        if (s[0]) m_hex[w-4] = d[6:0];
      end else if (w == 16) begin
        if (busy_pre) set = 1;
        else begin
          m_lcd = merge(m_lcd, d, s) & 32'h800001FF;
          t = 1;
        end
      end else if (w == 17) clr = s[0] & d[1];
    end
    m_ovr = set | (m_ovr & !clr);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".ledr"}, 64'(o_ledr), 64'(m_ledr));
    chk({tag, ".ledg"}, 64'(o_ledg), 64'(m_ledg));
    chk({tag, ".hex"}, 64'(o_hex), 64'(exp_hex()));
    chk({tag, ".lcd"}, 64'(o_lcd), 64'(m_lcd | ((t > S && t <= S + P) ? 32'h400 : 32'h0)));
    chk({tag, ".busy"}, 64'(o_lcd_busy), 64'(t != 0));
    chk({tag, ".rd"}, 64'(bus.rd_data), 64'(exp_rd(bus.rd_addr)));
  endtask

  task automatic tick(input string tag, input logic en, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [7:0] ra);
    bus.st_en = en; bus.st_addr = a; bus.st_data = d; bus.st_strb = s; bus.rd_addr = ra;
    #1;
    chk({tag, ".rd_pre"}, 64'(bus.rd_data), 64'(exp_rd(ra)));
    model_step(en, a, d, s);
    @(posedge clk);
    #1;
    bus.st_en = 0;
    check_outs(tag);
  endtask

  initial begin
    bus.st_en = 0; bus.st_addr = 0; bus.st_data = 0; bus.st_strb = 0; bus.rd_addr = 0;
    #2 rst = 1;
    #1;
    model_reset();
    check_outs("reset_async");
    chk("reset_hex_blank", 64'(o_hex), 64'h00FF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1 rst = 0;

    tick("ledr", 1, 8'h00, 32'hFFFF_FFFF, 4'b0011, 8'h00);
    chk("ledr_strb", 64'(o_ledr), 64'h0FFFF);
    chk("ledr_rd", 64'(bus.rd_data), 64'h0000FFFF);
    tick("ledg", 1, 8'h04, 32'h0000_01FF, 4'b1111, 8'h04);
    chk("ledg_val", 64'(o_ledg), 64'h1FF);
    tick("hex3", 1, 8'h1C, 32'h0000_0040, 4'b1111, 8'h1C);
    chk("hex3_val", 64'(o_hex[27:21]), 64'h40);
    tick("hex8", 1, 8'h30, 32'h0000_0012, 4'b1111, 8'h30);
    chk("hex8_rd", 64'(bus.rd_data), 64'h0);

    tick("lcd_go", 1, 8'h40, 32'h8000_0141, 4'b1111, 8'h44);
    for (int i = 1; i <= TOT; i++) begin
      chk("lcd_data", 64'(o_lcd[8:0]), 64'h141);
      chk("lcd_on", 64'(o_lcd[31]), 64'h1);
      chk("lcd_busy", 64'(o_lcd_busy), 64'h1);
      chk("lcd_en", 64'(o_lcd[10]), 64'(i > S && i <= S + P));
      if (i == 5) begin
        tick("lcd_ovr_pulse", 1, 8'h40, 32'h0000_0055, 4'b1111, 8'h44);
        chk("stat_3", 64'(bus.rd_data), 64'h3);
      end else if (i == TOT) tick("lcd_ovr_hold", 1, 8'h40, 32'h0000_0066, 4'b1111, 8'h44);
      else tick("lcd_run", 0, 8'h00, 32'h0, 4'b0000, 8'h44);
    end
    chk("stat_2", 64'(bus.rd_data), 64'h2);
    chk("lcd_kept", 64'(o_lcd), 64'h8000_0141);
    tick("stat_clr", 1, 8'h44, 32'h0000_0002, 4'b0001, 8'h44);
    chk("stat_0", 64'(bus.rd_data), 64'h0);

    for (int i = 0; i < 400; i++)
      tick("rand", ($urandom % 4) != 0, addrs[$urandom % 14] | 8'($urandom % 4), $urandom,
           4'($urandom), addrs[$urandom % 14]);

    for (int i = 0; i < TOT + 2 && t != 0; i++) tick("drain", 0, 8'h00, 32'h0, 4'b0000, 8'h44);
    chk("drained_idle", 64'(o_lcd_busy), 64'h0);
    tick("lcd_go2", 1, 8'h40, 32'h0000_01AA, 4'b1111, 8'h44);
    for (int i = 0; i < 4; i++) tick("to_pulse", 0, 8'h00, 32'h0, 4'b0000, 8'h44);
    chk("in_pulse_en", 64'(o_lcd[10]), 64'h1);
    #2 rst = 1;
    #1;
    model_reset();
    chk("rst_en_drop", 64'(o_lcd[10]), 64'h0);
    check_outs("rst_pulse");
    @(posedge clk);
    #1 rst = 0;
    tick("lcd_after_rst", 1, 8'h40, 32'h0000_0123, 4'b1111, 8'h44);
    chk("after_rst_stat", 64'(bus.rd_data), 64'h1);
    chk("after_rst_lcd", 64'(o_lcd), 64'h0000_0123);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/io_out_mmio.md
Name: io_out_mmio

Overview:
- Parametrised memory-mapped output peripheral for the pipelined core's store path. Successor to the fixed-width LED/HEX/LCD output block.
- Adds configurable LED widths and HEX digit count, byte-strobed stores, full readback, and an LCD write sequencer.
- The sequencer generates timed RS/EN strobes with a busy/overrun status, so software no longer bit-bangs the LCD enable line.

Parameters:
- LEDR_W, 18, red LED register width (1..32)
- LEDG_W, 9, green LED register width (1..32)
- NUM_HEX, 8, number of 7-segment digits (1..8)
- SETUP_CYC, 2, cycles RS/data stable before EN rises (>=1)
- PULSE_CYC, 12, cycles EN held high (>=1)
- HOLD_CYC, 2, cycles RS/data held after EN falls (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- st_en  in  1  store strobe, one cycle per store
- st_addr  in  8  byte offset within peripheral; bits [1:0] ignored
- st_data  in  32  store data
- st_strb  in  4  byte enables for st_data
- rd_addr  in  8  read byte offset; bits [1:0] ignored
- rd_data  out  32  combinational readback of the register at rd_addr
- o_ledr  out  LEDR_W  red LEDs
- o_ledg  out  LEDG_W  green LEDs
- o_hex  out  7*NUM_HEX  digit k occupies bits [7k+6:7k]; segments active-low
- o_lcd  out  32  packed LCD bus: [7:0] data, [8] RS, [9] RW (always 0), [10] EN, [31] ON
- o_lcd_busy  out  1  sequencer not IDLE

Behaviour:
- Reset: one clock; rst is asynchronous, active-high.
  - Asserting rst immediately forces o_ledr=0, o_ledg=0, every digit=7'h7F (blank), o_lcd=0 (EN low), FSM=IDLE, overrun=0, o_lcd_busy=0.
  - Reset mid-sequence aborts it with EN dropping in the same cycle.
- Register map (word offsets):
  - 0x00 LEDR, RW
  - 0x04 LEDG, RW
  - 0x10+4k HEX k for k<NUM_HEX, RW, bits [6:0]
  - 0x40 LCD_DATA, write starts a sequence; reads return the latched {ON,RS,data}
  - 0x44 LCD_STAT: bit0 busy (RO), bit1 overrun (sticky); writing 1 to bit1 clears it
  - Other offsets: writes ignored, reads 0.
- Stores:
  - Take effect on the clk edge where st_en=1.
  - Each byte is written only where its st_strb bit is 1.
  - Register bits above the register's width are dropped on write and read back as 0.
  - st_en=0 leaves all state unchanged. There is no clear-on-unmapped-store behaviour.
- Readback: rd_data is purely combinational from rd_addr and current register state. A store and a read to the same address in the same cycle return the old value.
- LCD_DATA store:
  - Accepted only when FSM=IDLE. It latches data=st_data[7:0], RS=st_data[8], ON=st_data[31], with byte strobes honoured against the previous latched value.
  - Accepted store: FSM goes IDLE->SETUP on that edge.
  - Store while not IDLE: ignored, sets overrun=1.
  - A store on the final HOLD cycle still counts as busy and is rejected with overrun.
- Sequencer FSM. One down-counter, loaded on each state entry.
  - IDLE: EN=0, busy=0.
  - SETUP: lasts SETUP_CYC cycles, EN=0, then PULSE.
  - PULSE: lasts PULSE_CYC cycles, EN=1, then HOLD.
  - HOLD: lasts HOLD_CYC cycles, EN=0, then IDLE.
  - o_lcd data/RS/ON reflect the latched values continuously, including in IDLE.
  - Busy is high from the cycle after the accepting edge through the last HOLD cycle.
  - Total busy time = SETUP_CYC+PULSE_CYC+HOLD_CYC cycles.
- Overrun clear: a write to LCD_STAT with bit1=1 on the same edge as a new overrun event leaves overrun=1 (set wins).
- All outputs are registered: no combinational path from st_* to o_*.

Test Plan:
- Reset with rst asserted mid-cycle, no clk edge -> o_ledr=0, o_ledg=0, o_hex all 7'h7F, o_lcd=0, busy=0.
- Store 0x00 data 0xFFFF_FFFF strb 4'b0011, then read 0x00 -> o_ledr=18'h0FFFF and rd_data=0x0000FFFF. Store 0x04 0x1FF strb 4'b1111 -> o_ledg=9'h1FF.
- Store HEX3 (0x1C) 0x40 -> o_hex[27:21]=7'h40, other digits unchanged. Store to 0x30 (k=8) with NUM_HEX=8 -> no change, read returns 0.
- Store LCD_DATA 0x8000_0141 -> busy next cycle; EN=0 for 2 cycles, EN=1 for 12, EN=0 for 2, then IDLE. o_lcd[8:0]=9'h141 and o_lcd[31]=1 throughout.
- Second LCD_DATA store during PULSE and on the last HOLD cycle -> both ignored, latched data unchanged, LCD_STAT reads 0x3 then 0x2. Write 0x2 to 0x44 -> reads 0x0.
- Assert rst during PULSE -> EN falls immediately. After release, FSM=IDLE, and a new LCD store is accepted without overrun.
